// File: rtl/fault_confinement.sv
// fault_confinement: transmit/receive error counters and error-state tracking
// for a CAN-style node, including bus-off entry and idle-based recovery.
// All outputs are registered and reflect the events seen on the previous edge.
module fault_confinement #(
   parameter int WARN_LIMIT     = 96,
   parameter int RECOVERY_COUNT = 128
) (
   input  logic       clk,
   input  logic       g_rst,
   input  logic       tx_err,
   input  logic       ack_err,
   input  logic       tx_success,
   input  logic       rx_err,
   input  logic       rx_err_prim,
   input  logic       rx_success,
   input  logic       idle_11,
   output logic [8:0] tec,
   output logic [7:0] rec,
   output logic [1:0] err_state,
   output logic       err_active,
   output logic       err_passive,
   output logic       bus_off,
   output logic       err_warn,
   output logic       bus_off_evt
);

   // Error-state encodings (11 is never produced)
   localparam logic [1:0] ST_ACTIVE  = 2'b00;
   localparam logic [1:0] ST_PASSIVE = 2'b01;
   localparam logic [1:0] ST_BUS_OFF = 2'b10;

   // Counter thresholds
   localparam logic [8:0] WARN_THRESH   = 9'(WARN_LIMIT);
   localparam logic [8:0] TEC_MAX       = 9'd256;
   localparam logic [8:0] TEC_ADD_SAT   = 9'd248;   // tec at/above this clamps to 256 on +8
   localparam logic [8:0] PASSIVE_ABOVE = 9'd127;
   localparam logic [8:0] BUS_OFF_ABOVE = 9'd255;
   localparam logic [7:0] REC_MAX       = 8'd255;
   localparam logic [7:0] REC_ADD_SAT   = 8'd247;   // rec above this saturates to 255 on +8
   localparam logic [7:0] REC_RELOAD    = 8'd120;
   localparam logic [7:0] REC_HIGH      = 8'd127;
   localparam logic [7:0] RECOV_LAST    = 8'(RECOVERY_COUNT - 1);

   // State registers
   logic [8:0] tec_reg,       tec_next;
   logic [7:0] rec_reg,       rec_next;
   logic [1:0] state_reg,     state_next;
   logic [7:0] recov_reg,     recov_next;
   logic       warn_reg,      warn_next;
   logic       evt_reg,       evt_next;
   logic       active_reg;
   logic       passive_reg;
   logic       bus_off_reg;

   // Candidate counter values from the tx/rx events (used only outside bus-off)
   logic [8:0] tec_upd;
   logic [7:0] rec_upd;
   logic       in_bus_off;
   logic       recov_done;

   assign in_bus_off = (state_reg == ST_BUS_OFF);
   assign recov_done = in_bus_off && idle_11 && (recov_reg == RECOV_LAST);

   // Transmit counter update: tx_err (+8, clamped) wins over tx_success (-1);
   // an ack error while error-passive leaves tec untouched.
   always_comb begin
      tec_upd = tec_reg;
      if (tx_err) begin
         if (!(ack_err && (state_reg == ST_PASSIVE))) begin
            if (tec_reg >= TEC_ADD_SAT) begin
               tec_upd = TEC_MAX;
            end else begin
               tec_upd = tec_reg + 9'd8;
            end
         end
      end else if (tx_success && (tec_reg != 9'd0)) begin
         tec_upd = tec_reg - 9'd1;
      end
   end

   // Receive counter update: primary error (+8) dominates plain error (+1),
   // both dominate rx_success; high counts reload to 120 on success.
   always_comb begin
      rec_upd = rec_reg;
      if (rx_err_prim) begin
         if (rec_reg > REC_ADD_SAT) begin
            rec_upd = REC_MAX;
         end else begin
            rec_upd = rec_reg + 8'd8;
         end
      end else if (rx_err) begin
         if (rec_reg != REC_MAX) begin
            rec_upd = rec_reg + 8'd1;
         end
      end else if (rx_success) begin
         if (rec_reg > REC_HIGH) begin
            rec_upd = REC_RELOAD;
         end else if (rec_reg != 8'd0) begin
            rec_upd = rec_reg - 8'd1;
         end
      end
   end

   // Next-state selection: bus-off freezes the counters and only counts
   // idle_11 pulses; otherwise the state follows the updated counters.
   always_comb begin
      tec_next   = tec_reg;
      rec_next   = rec_reg;
      state_next = state_reg;
      recov_next = recov_reg;
      if (in_bus_off) begin
         if (recov_done) begin
            tec_next   = 9'd0;
            rec_next   = 8'd0;
            state_next = ST_ACTIVE;
            recov_next = 8'd0;
         end else if (idle_11) begin
            recov_next = recov_reg + 8'd1;
         end
      end else begin
         tec_next   = tec_upd;
         rec_next   = rec_upd;
         // Held at zero outside bus-off, so every bus-off entry starts a fresh count
         recov_next = 8'd0;
         if (tec_upd > BUS_OFF_ABOVE) begin
            state_next = ST_BUS_OFF;
         end else if ((tec_upd > PASSIVE_ABOVE) || ({1'b0, rec_upd} > PASSIVE_ABOVE)) begin
            state_next = ST_PASSIVE;
         end else begin
            state_next = ST_ACTIVE;
         end
      end
   end

   // Derived flags computed from the same next values so outputs stay consistent
   always_comb begin
      warn_next = (tec_next >= WARN_THRESH) || ({1'b0, rec_next} >= WARN_THRESH);
      evt_next  = (state_next == ST_BUS_OFF) && !in_bus_off;
   end

   // Register counters, state, flags and one-hot decode; reset has top priority
   always_ff @(posedge clk) begin
      if (g_rst) begin
         tec_reg     <= 9'd0;
         rec_reg     <= 8'd0;
         state_reg   <= ST_ACTIVE;
         recov_reg   <= 8'd0;
         warn_reg    <= 1'b0;
         evt_reg     <= 1'b0;
         active_reg  <= 1'b1;
         passive_reg <= 1'b0;
         bus_off_reg <= 1'b0;
      end else begin
         tec_reg     <= tec_next;
         rec_reg     <= rec_next;
         state_reg   <= state_next;
         recov_reg   <= recov_next;
         warn_reg    <= warn_next;
         evt_reg     <= evt_next;
         active_reg  <= (state_next == ST_ACTIVE);
         passive_reg <= (state_next == ST_PASSIVE);
         bus_off_reg <= (state_next == ST_BUS_OFF);
      end
   end

   assign tec         = tec_reg;
   assign rec         = rec_reg;
   assign err_state   = state_reg;
   assign err_active  = active_reg;
   assign err_passive = passive_reg;
   assign bus_off     = bus_off_reg;
   assign err_warn    = warn_reg;
   assign bus_off_evt = evt_reg;

endmodule

// File: doc/fault_confinement.md
FAULT_CONFINEMENT -- requirements
Module: fault_confinement

Interface
REQ-001 SHALL provide parameter WARN_LIMIT, default 96, the error-warning threshold applied to both tec and rec.
REQ-002 SHALL provide parameter RECOVERY_COUNT, default 128, the number of idle_11 pulses required for bus-off recovery.
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port g_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port tx_err  input  1  one-cycle pulse: transmitter error detected (ack, bit, form, stuff, crc).
REQ-006 SHALL provide port ack_err  input  1  qualifies tx_err: the error is an acknowledgement error, driven directly from the ack checker's registered output.
REQ-007 SHALL provide port tx_success  input  1  one-cycle pulse: frame transmitted successfully.
REQ-008 SHALL provide port rx_err  input  1  one-cycle pulse: receiver error detected.
REQ-009 SHALL provide port rx_err_prim  input  1  one-cycle pulse: receiver saw dominant bit after its own error flag.
REQ-010 SHALL provide port rx_success  input  1  one-cycle pulse: frame received successfully.
REQ-011 SHALL provide port idle_11  input  1  one-cycle pulse per 11 consecutive recessive bits.
REQ-012 SHALL provide port tec  output  9  transmit error counter, range 0..256.
REQ-013 SHALL provide port rec  output  8  receive error counter, range 0..255.
REQ-014 SHALL provide port err_state  output  2  00 error-active, 01 error-passive, 10 bus-off; 11 never driven.
REQ-015 SHALL provide ports err_active, err_passive, bus_off  output  1 each  one-hot decode of err_state; err_active and err_passive select active or passive error-flag transmission.
REQ-016 SHALL provide port err_warn  output  1  high while tec >= WARN_LIMIT or rec >= WARN_LIMIT.
REQ-017 SHALL provide port bus_off_evt  output  1  one-cycle pulse on the cycle err_state becomes bus-off.

Function
REQ-018 SHALL register all outputs; an event pulse at edge N SHALL be reflected in tec, rec, err_state and err_warn after edge N (1-cycle latency), all mutually consistent.
REQ-019 SHALL add 8 to tec on tx_err, except no change when ack_err=1 and err_state=error-passive.
REQ-020 SHALL decrement tec by 1 on tx_success when tec>0; tec=0 holds.
REQ-021 SHALL give tx_err priority over a simultaneous tx_success; only the tx_err update applies.
REQ-022 SHALL clamp tec at 256 (no wrap).
REQ-023 SHALL add 8 to rec on rx_err_prim and 1 on rx_err; when both are present the increment SHALL be 8 only.
REQ-024 SHALL saturate rec at 255.
REQ-025 SHALL, on rx_success, load rec=120 when rec>127, decrement by 1 when 1..127, hold at 0.
REQ-026 SHALL give rx_err and rx_err_prim priority over a simultaneous rx_success.
REQ-027 SHALL update tec and rec independently in the same cycle when tx and rx events coincide.
REQ-028 SHALL derive next err_state from the updated counters: bus-off if tec_next>255; else error-passive if tec_next>127 or rec_next>127; else error-active.
REQ-029 SHALL, while bus-off, ignore tx_err, ack_err, tx_success, rx_err, rx_err_prim and rx_success; tec and rec hold.
REQ-030 SHALL clear an internal 8-bit recovery counter on bus-off entry and increment it on each idle_11 pulse while bus-off; idle_11 outside bus-off SHALL have no effect.
REQ-031 SHALL, on the idle_11 pulse that brings the recovery counter to RECOVERY_COUNT, set tec=0, rec=0, err_state=error-active and clear the recovery counter after that edge.
REQ-032 SHALL never transition bus-off to error-passive; the only exit from bus-off is recovery or reset.

Reset
REQ-033 SHALL, on g_rst=1 at a clock edge, set tec=0, rec=0, err_state=00, err_active=1, err_passive=0, bus_off=0, err_warn=0, bus_off_evt=0 and recovery counter=0.
REQ-034 SHALL give g_rst priority over every simultaneous input, including mid-recovery.

Verification
REQ-035 SHALL test: 16 tx_err pulses (ack_err=0) from reset -> err_warn=1 after the 12th (tec=96); tec=128 and err_passive=1 after the 16th.
REQ-036 SHALL test: tec=128 passive, tx_err with ack_err=1 -> tec stays 128; next tx_err with ack_err=0 -> tec=136.
REQ-037 SHALL test: tec=248, tx_err -> tec=256, bus_off=1, bus_off_evt high exactly 1 cycle; rx_err then ignored; after 127 idle_11 still bus-off; 128th -> tec=0, rec=0, err_active=1.
REQ-038 SHALL test: rec=130, tec=5, rx_success -> rec=120, err_active=1; simultaneous rx_err+rx_err_prim at rec=0 -> rec=8.
REQ-039 SHALL test: tec=10, tx_err and tx_success same cycle -> tec=18; tx_success at tec=0 -> tec=0.
REQ-040 SHALL test: g_rst asserted at recovery count 50 -> next cycle all outputs at reset values; a later bus-off entry requires a full 128 idle_11 pulses.
